ifu_fetch_ctrl: RTL and testbench

- Fetch sequencer between the instruction bus and the IF/ID pipeline register.
- Issues one instruction-bus read at a time and presents the returned word plus its PC to IF/ID with a valid/ready handshake.
- Handles redirects (branch/trap) by flushing IF/ID and discarding any in-flight response.
- Keeps at most one outstanding request, so no reorder buffering is needed.

---
 rtl/ifu_fetch_ctrl_pkg.sv | 15 +
 rtl/ifu_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifu_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DefaultResetPc = 32'h3000_0000;
    localparam logic [31:0] DefaultPcStep  = 32'd4;
    localparam logic [31:0] InstNop        = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: one outstanding instruction-bus read, result handed to IF/ID via valid/ready.
// Redirects flush IF/ID and discard any response still in flight.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter logic [31:0] PC_STEP  = DefaultPcStep
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_flush,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic [15:0] drop_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  opc_q, opc_d;
    logic         err_q, err_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;
    logic         drop_inc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        opc_d    = opc_q;
        err_d    = err_q;
        drop_inc = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over every other event; only the FSM's view of
            // what is still outstanding on the bus decides the next state.
            pc_d = redirect_pc & ~32'd3;
            unique case (state_q)
                StReq:  state_d = req_ready ? StDrop : StReq;
                StWait: begin
                    drop_inc = resp_valid;
                    state_d  = resp_valid ? StReq : StDrop;
                end
                StHold: state_d = StReq;
                StDrop: begin
                    drop_inc = resp_valid;
                    state_d  = resp_valid ? StReq : StDrop;
                end
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (req_ready) state_d = StWait;
                end
                StWait: begin
                    if (resp_valid) begin
                        inst_d  = resp_data;
                        err_d   = resp_err;
                        opc_d   = pc_q;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = StReq;
                    end
                end
                StDrop: begin
                    if (resp_valid) begin
                        drop_inc = 1'b1;
                        state_d  = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end

        drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            inst_q     <= InstNop;
            opc_q      <= RESET_PC;
            err_q      <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            opc_q      <= opc_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ifid_flush = redirect_valid;
    assign req_valid  = (state_q == StReq) && !reset;
    assign req_addr   = pc_q;
    assign out_valid  = (state_q == StHold);
    assign out_inst   = inst_q;
    assign out_pc     = opc_q;
    assign out_err    = err_q;
    assign drop_cnt   = drop_cnt_q;

`ifndef SYNTHESIS
    // A response with nothing outstanding means the bus broke protocol; the RTL ignores it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(resp_valid && (state_q == StReq || state_q == StHold)))
                else $error("ifu_fetch_ctrl: resp_valid with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: scoreboard of delivered instructions plus per-feature tasks.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
    logic [15:0] drop_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ifu_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_flush     (ifid_flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_err        (out_err),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every accepted IF/ID handshake must match the oldest expected fetch.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL delivery: unexpected inst %h pc %h err %b, none expected",
                         out_inst, out_pc, out_err);
            end else begin
                e = exp_q.pop_front();
                if ({out_pc, out_inst, out_err} !== e) begin
                    n_bad++;
                    $display("FAIL delivery: got pc %h inst %h err %b, expected pc %h inst %h err %b",
                             out_pc, out_inst, out_err, e.pc, e.inst, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input logic [31:0] pc, input logic [31:0] data, input logic err);
        resp_valid = 1'b1;
        resp_data  = data;
        resp_err   = err;
        exp_q.push_back({pc, data, err});
    endtask

    // Drive one complete fetch starting from REQ; delivery is checked by the scoreboard.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input logic err,
                         input int lat);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat (lat) tick();
        push_resp(pc, data, err);
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        resp_data = 32'h0;
        resp_err = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({req_valid, out_valid, out_err, drop_cnt} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rv %b ov %b err %b drop %h, expected 0 0 0 0000",
                     req_valid, out_valid, out_err, drop_cnt);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h3000_0000}) begin
            n_bad++;
            $display("FAIL reset_first_req: got rv %b addr %h, expected 1 30000000",
                     req_valid, req_addr);
        end
    endtask

    task automatic test_basic();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        n_cmp++;
        if ({req_valid, out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_wait: got rv %b ov %b, expected 0 0", req_valid, out_valid);
        end
        push_resp(32'h3000_0000, 32'h0010_0093, 1'b0);
        tick();
        resp_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h3000_0000, 32'h0010_0093}) begin
            n_bad++;
            $display("FAIL basic_hold: got ov %b pc %h inst %h, expected 1 30000000 00100093",
                     out_valid, out_pc, out_inst);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h3000_0004}) begin
            n_bad++;
            $display("FAIL basic_next_req: got rv %b addr %h, expected 1 30000004",
                     req_valid, req_addr);
        end
    endtask

    task automatic test_backpressure();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        push_resp(32'h3000_0004, 32'h0020_0113, 1'b0);
        tick();
        resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, out_inst, out_pc, req_valid} !==
                {1'b1, 32'h0020_0113, 32'h3000_0004, 1'b0}) begin
                n_bad++;
                $display("FAIL backpressure_hold[%0d]: got ov %b inst %h pc %h rv %b, expected 1 00200113 30000004 0",
                         i, out_valid, out_inst, out_pc, req_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h3000_0008}) begin
            n_bad++;
            $display("FAIL backpressure_advance: got rv %b addr %h, expected 1 30000008",
                     req_valid, req_addr);
        end
    endtask

    task automatic test_resp_err();
        fetch(32'h3000_0008, 32'h0030_0193, 1'b0, 1);
        fetch(32'h3000_000C, 32'h0040_0213, 1'b0, 0);
        n_cmp++;
        if (req_addr !== 32'h3000_0010) begin
            n_bad++;
            $display("FAIL err_pre_addr: got %h, expected 30000010", req_addr);
        end
        fetch(32'h3000_0010, 32'hFFFF_FFFF, 1'b1, 2);
        n_cmp++;
        if (req_addr !== 32'h3000_0014) begin
            n_bad++;
            $display("FAIL err_next_addr: got %h, expected 30000014", req_addr);
        end
        fetch(32'h3000_0014, 32'h0050_0293, 1'b0, 0);
    endtask

    task automatic test_redirect_wait();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        #1;
        n_cmp++;
        if (ifid_flush !== 1'b1) begin
            n_bad++;
            $display("FAIL redirect_wait_flush: got %b, expected 1", ifid_flush);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({ifid_flush, req_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL redirect_wait_drop: got flush %b rv %b, expected 0 0",
                     ifid_flush, req_valid);
        end
        tick();
        tick();
        resp_valid = 1'b1;
        resp_data = 32'hDEAD_BEEF;
        tick();
        resp_valid = 1'b0;
        n_cmp++;
        if ({drop_cnt, req_valid, req_addr, out_valid} !== {16'd1, 1'b1, 32'h8000_0100, 1'b0}) begin
            n_bad++;
            $display("FAIL redirect_wait_after: got drop %h rv %b addr %h ov %b, expected 0001 1 80000100 0",
                     drop_cnt, req_valid, req_addr, out_valid);
        end
    endtask

    task automatic test_redirect_hold();
        exp_t abandoned;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        push_resp(32'h8000_0100, 32'h0000_0013, 1'b0);
        tick();
        resp_valid = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h9000_0040;
        abandoned = exp_q.pop_front();
        #1;
        n_cmp++;
        if ({ifid_flush, out_valid} !== 2'b11) begin
            n_bad++;
            $display("FAIL redirect_hold_flush: got flush %b ov %b, expected 1 1",
                     ifid_flush, out_valid);
        end
        tick();
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({req_valid, req_addr, out_valid, drop_cnt} !== {1'b1, 32'h9000_0040, 1'b0, 16'd1}) begin
            n_bad++;
            $display("FAIL redirect_hold_target: got rv %b addr %h ov %b drop %h, expected 1 90000040 0 0001 (abandoned pc %h)",
                     req_valid, req_addr, out_valid, drop_cnt, abandoned.pc);
        end
    endtask

    task automatic test_redirect_wait_resp();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 32'hBAD0_0001;
        redirect_valid = 1'b1;
        redirect_pc = 32'h9000_0081;
        tick();
        resp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({drop_cnt, req_valid, req_addr, out_valid} !== {16'd2, 1'b1, 32'h9000_0080, 1'b0}) begin
            n_bad++;
            $display("FAIL redirect_wait_resp: got drop %h rv %b addr %h ov %b, expected 0002 1 90000080 0",
                     drop_cnt, req_valid, req_addr, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc = 32'hA000_0000;
        tick();
        redirect_pc = 32'hA000_0010;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'hA000_0010}) begin
            n_bad++;
            $display("FAIL b2b_last_wins: got rv %b addr %h, expected 1 a0000010",
                     req_valid, req_addr);
        end
        req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hB000_0000;
        tick();
        req_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept_drop: got rv %b, expected 0", req_valid);
        end
        resp_valid = 1'b1;
        resp_data = 32'hBAD0_0002;
        tick();
        resp_valid = 1'b0;
        n_cmp++;
        if ({drop_cnt, req_valid, req_addr} !== {16'd3, 1'b1, 32'hB000_0000}) begin
            n_bad++;
            $display("FAIL b2b_after_drop: got drop %h rv %b addr %h, expected 0003 1 b0000000",
                     drop_cnt, req_valid, req_addr);
        end
        fetch(32'hB000_0000, 32'h0060_0313, 1'b0, 0);
        n_cmp++;
        if (req_addr !== 32'hB000_0004) begin
            n_bad++;
            $display("FAIL b2b_resume: got %h, expected b0000004", req_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (req_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_target: got %h, expected fffffffc", req_addr);
        end
        fetch(32'hFFFF_FFFC, 32'h0070_0393, 1'b0, 1);
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h0000_0000}) begin
            n_bad++;
            $display("FAIL wrap_next: got rv %b addr %h, expected 1 00000000", req_valid, req_addr);
        end
    endtask

    task automatic test_reset_mid();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_req: got rv %b, expected 0", req_valid);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({req_valid, req_addr, out_valid, drop_cnt} !== {1'b1, 32'h3000_0000, 1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_after: got rv %b addr %h ov %b drop %h, expected 1 30000000 0 0000",
                     req_valid, req_addr, out_valid, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_resp_err();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_wait_resp();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d undelivered, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
